// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  // Default bus geometry for memory_block.
  localparam int ADDR_W_DEFAULT = 18;
  localparam int DATA_W_DEFAULT = 32;

  // Width of the byte lane used by byte loads/stores.
  localparam int BYTE_W = 8;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    VERIFY = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Larger of two integers, used to size the shared wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus memory_block strobe bundle.
// Latency: n/a (wires only).
// Backpressure: req_ready gates acceptance; responses cannot be stalled.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) ();

  // Request side (MEM pipeline stage -> controller)
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Response side (controller -> MEM pipeline stage)
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // memory_block port
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic              mem_byte_operations;
  logic [DATA_W-1:0] mem_read_data;

  // Controller view.
  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_data, mem_read, mem_write, mem_byte_operations,
    input  mem_read_data
  );

  // Requester plus memory view.
  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_data, mem_read, mem_write, mem_byte_operations,
    output mem_read_data
  );

endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Formats a memory word: passthrough for word access, byte lane sign/zero extended otherwise.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              byte_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic ext_bit;

  assign ext_bit = signed_i & data_i[BYTE_W-1];

  // Select word passthrough or extended low byte.
  always_comb begin
    data_o = data_i;
    if (byte_i) begin
      data_o = {{(DATA_W-BYTE_W){ext_bit}}, data_i[BYTE_W-1:0]};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer driving memory_block strobes; one request in flight. Optional MEM_STORE_READBACK_EN adds store verify.
// Latency: load T+RD_WAIT+1, store T+WR_HOLD+1 (T+WR_HOLD+RD_WAIT+1 with readback).
// Backpressure: req_ready only in IDLE; single-cycle resp_valid cannot be stalled.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int RD_WAIT = 1,
  parameter int WR_HOLD = 1
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  // A zero-cycle strobe would never reach memory_block, so both holds clamp to 1.
  localparam int RD_CYC = (RD_WAIT < 1) ? 1 : RD_WAIT;
  localparam int WR_CYC = (WR_HOLD < 1) ? 1 : WR_HOLD;
  localparam int CNT_W  = $clog2(max_int(RD_CYC, WR_CYC) + 1);

  // Counter reload values: the counter hits zero on the final strobe cycle.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              byte_q;
  logic              signed_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              rd_done;
  logic              wr_done;
  logic              vfy_done;
  logic [DATA_W-1:0] rd_fmt;

  // Readback compares raw lanes, so extension is disabled while verifying.
  load_extend #(.DATA_W(DATA_W)) u_rd_fmt (
    .data_i   (bus.mem_read_data),
    .byte_i   (byte_q),
    .signed_i (signed_q && (state_q != VERIFY)),
    .data_o   (rd_fmt)
  );

`ifdef MEM_STORE_READBACK_EN
  logic              err_q;
  logic [DATA_W-1:0] wd_fmt;

  // Store data reduced to the same lane view as the readback.
  load_extend #(.DATA_W(DATA_W)) u_wd_fmt (
    .data_i   (wdata_q),
    .byte_i   (byte_q),
    .signed_i (1'b0),
    .data_o   (wd_fmt)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter reload on every state entry, and datapath capture strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    vfy_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = bus.req_write ? WR : RD;
          cnt_d   = bus.req_write ? WR_LOAD : RD_LOAD;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rd_done = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          wr_done = 1'b1;
`ifdef MEM_STORE_READBACK_EN
          state_d = VERIFY;
          cnt_d   = RD_LOAD;
`else
          state_d = RESP;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      VERIFY: begin
`ifdef MEM_STORE_READBACK_EN
        if (cnt_q == '0) begin
          vfy_done = 1'b1;
          state_d  = RESP;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch and response data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        byte_q   <= bus.req_byte;
        signed_q <= bus.req_signed;
      end
      if (rd_done) begin
        rdata_q <= rd_fmt;
      end
      if (wr_done) begin
        rdata_q <= '0;
      end
    end
  end

`ifdef MEM_STORE_READBACK_EN
  // Readback mismatch flag, cleared per request and set on the final verify cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (vfy_done) begin
      err_q <= (rd_fmt != wd_fmt);
    end
  end

  assign bus.resp_err = err_q && (state_q == RESP);
`else
  assign bus.resp_err = 1'b0;
`endif

  // Strobes decode straight from the registered state, so read and write are mutually exclusive.
  assign bus.req_ready           = (state_q == IDLE);
  assign bus.resp_valid          = (state_q == RESP);
  assign bus.resp_rdata          = rdata_q;
  assign bus.mem_read            = (state_q == RD) || (state_q == VERIFY);
  assign bus.mem_write           = (state_q == WR);
  assign bus.mem_byte_operations = byte_q &&
                                   ((state_q == RD) || (state_q == WR) || (state_q == VERIFY));
  assign bus.mem_address         = addr_q;
  assign bus.mem_write_data      = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-addressed memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_ctrl;

`ifdef MEM_STORE_READBACK_EN
  localparam int ST_LAT  = 3;
  localparam int ST_RCNT = 1;
`else
  localparam int ST_LAT  = 2;
  localparam int ST_RCNT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  logic corrupt;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(18), .DATA_W(32)) bus ();
  mem_access_ctrl_if #(.ADDR_W(18), .DATA_W(32)) bus2 ();

  mem_access_ctrl #(.ADDR_W(18), .DATA_W(32), .RD_WAIT(1), .WR_HOLD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mem_access_ctrl #(.ADDR_W(18), .DATA_W(32), .RD_WAIT(3), .WR_HOLD(1)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2.slave)
  );

  // Memory model: preloaded on reset, word 0 = A5A5A5A5.
  logic [7:0] mem [0:255];
  logic [7:0] a0;
  assign a0 = bus.mem_address[7:0];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hA5;
      mem[1] <= 8'hA5;
      mem[2] <= 8'hA5;
      mem[3] <= 8'hA5;
    end else if (bus.mem_write) begin
      if (bus.mem_byte_operations) begin
        mem[a0] <= bus.mem_write_data[7:0];
      end else begin
        mem[a0]        <= bus.mem_write_data[7:0];
        mem[a0 + 8'd1] <= bus.mem_write_data[15:8];
        mem[a0 + 8'd2] <= bus.mem_write_data[23:16];
        mem[a0 + 8'd3] <= bus.mem_write_data[31:24];
      end
    end
  end

  // Byte reads put junk in the upper lanes so extension is really exercised.
  always_comb begin
    if (bus.mem_byte_operations) bus.mem_read_data = {24'h5A5A5A, mem[a0]};
    else bus.mem_read_data = {mem[a0 + 8'd3], mem[a0 + 8'd2], mem[a0 + 8'd1], mem[a0]};
    if (corrupt) bus.mem_read_data = bus.mem_read_data ^ 32'h0000_0001;
  end

  assign bus2.mem_read_data = 32'hCAFE_F00D;

  int overlap = 0;
  always @(negedge clk) begin
    if ((bus.mem_read && bus.mem_write) || (bus2.mem_read && bus2.mem_write)) overlap++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on bus; reports response data/err, latency (cycles after accept) and strobe counts.
  task automatic access(input logic wr, input logic byt, input logic sgn,
                        input logic [17:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int rcnt, output int wcnt, output int bad);
    int n;
    @(negedge clk);
    bus.req_write  = wr;
    bus.req_byte   = byt;
    bus.req_signed = sgn;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; rcnt = 0; wcnt = 0; bad = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      if (bus.mem_read)  rcnt++;
      if (bus.mem_write) wcnt++;
      if ((bus.mem_read || bus.mem_write) &&
          (bus.mem_byte_operations !== byt || bus.mem_address !== a)) bad++;
      if (bus.mem_write && !byt && bus.mem_write_data !== wd) bad++;
      if (bus.req_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, rc, wc, bad;
    logic [3:0]  rpat;
    int          resp_n, k2;
    logic [31:0] r1, r2;

    reset = 1'b1; reset2 = 1'b1; corrupt = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_byte = 1'b0;
    bus2.req_signed = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_strobes", {29'd0, bus.mem_read, bus.mem_write, bus.mem_byte_operations}, 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_wdata", bus.mem_write_data, 32'h0);

    // 2: word load of preloaded word
    access(1'b0, 1'b0, 1'b0, 18'd0, 32'h0, rd, err, lat, rc, wc, bad);
    chk("ld0_data", rd, 32'hA5A5A5A5);
    chk("ld0_lat", 32'(lat), 32'd2);
    chk("ld0_rd_cycles", 32'(rc), 32'd1);
    chk("ld0_wr_cycles", 32'(wc), 32'd0);
    chk("ld0_stable", 32'(bad), 32'd0);
    @(negedge clk);
    chk("ld0_pulse_once", 32'(bus.resp_valid), 32'd0);
    chk("ld0_rdata_hold", bus.resp_rdata, 32'hA5A5A5A5);

    // 3: word store then reload
    access(1'b1, 1'b0, 1'b0, 18'd0, 32'h12345678, rd, err, lat, rc, wc, bad);
    chk("st0_rdata_zero", rd, 32'h0);
    chk("st0_err", 32'(err), 32'd0);
    chk("st0_lat", 32'(lat), 32'(ST_LAT));
    chk("st0_wr_cycles", 32'(wc), 32'd1);
    chk("st0_rd_cycles", 32'(rc), 32'(ST_RCNT));
    chk("st0_stable", 32'(bad), 32'd0);
    access(1'b0, 1'b0, 1'b0, 18'd0, 32'h0, rd, err, lat, rc, wc, bad);
    chk("ld_after_st", rd, 32'h12345678);

    // 4: byte store 9C to addr 1, then byte loads and a word load
    access(1'b1, 1'b1, 1'b0, 18'd1, 32'h0000009C, rd, err, lat, rc, wc, bad);
    chk("stb_lat", 32'(lat), 32'(ST_LAT));
    chk("stb_err", 32'(err), 32'd0);
    chk("stb_stable", 32'(bad), 32'd0);
    access(1'b0, 1'b1, 1'b1, 18'd1, 32'h0, rd, err, lat, rc, wc, bad);
    chk("ldb_signed", rd, 32'hFFFFFF9C);
    chk("ldb_signed_byteop", 32'(bad), 32'd0);
    access(1'b0, 1'b1, 1'b0, 18'd1, 32'h0, rd, err, lat, rc, wc, bad);
    chk("ldb_unsigned", rd, 32'h0000009C);
    chk("ldb_unsigned_byteop", 32'(bad), 32'd0);
    access(1'b0, 1'b0, 1'b0, 18'd0, 32'h0, rd, err, lat, rc, wc, bad);
    chk("ld_word_merged", rd, 32'h12349C78);

    // 5: back-to-back with req_valid held high
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = 18'd0; bus.req_valid = 1'b1;
    rpat = '0; resp_n = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 4) rpat[k-1] = bus.req_ready;
      if (bus.resp_valid) begin
        resp_n++;
        if (resp_n == 1) r1 = bus.resp_rdata;
        else r2 = bus.resp_rdata;
      end
      if (k == 1) begin
        bus.req_byte = 1'b1; bus.req_signed = 1'b1; bus.req_addr = 18'd1;
      end
      if (k == 4) bus.req_valid = 1'b0;
    end
    chk("b2b_ready_pattern", 32'(rpat), 32'h4);
    chk("b2b_resp_count", 32'(resp_n), 32'd2);
    chk("b2b_first", r1, 32'h12349C78);
    chk("b2b_second", r2, 32'hFFFFFF9C);

`ifdef MEM_STORE_READBACK_EN
    // readback mismatch forced by the memory model
    corrupt = 1'b1;
    access(1'b1, 1'b0, 1'b0, 18'd8, 32'h55AA00FF, rd, err, lat, rc, wc, bad);
    corrupt = 1'b0;
    chk("vfy_err", 32'(err), 32'd1);
    chk("vfy_lat", 32'(lat), 32'd3);
    @(negedge clk);
    chk("vfy_err_only_in_resp", 32'(bus.resp_err), 32'd0);
`else
    access(1'b1, 1'b0, 1'b0, 18'd8, 32'h55AA00FF, rd, err, lat, rc, wc, bad);
    chk("st8_err_tied", 32'(err), 32'd0);
    chk("st8_lat", 32'(lat), 32'd2);
`endif

    // 6a: RD_WAIT=3 full load on second instance
    @(negedge clk);
    bus2.req_addr = 18'd4; bus2.req_valid = 1'b1;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    k2 = 1; rc = 0;
    while (bus2.resp_valid !== 1'b1 && k2 < 20) begin
      if (bus2.mem_read) rc++;
      @(negedge clk);
      k2++;
    end
    chk("rw3_lat", 32'(k2), 32'd4);
    chk("rw3_rd_cycles", 32'(rc), 32'd3);
    chk("rw3_data", bus2.resp_rdata, 32'hCAFEF00D);

    // 6b: reset during the second RD cycle
    @(negedge clk);
    bus2.req_valid = 1'b1;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    chk("abort_rd_first", 32'(bus2.mem_read), 32'd1);
    @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk);
    chk("abort_rd_dropped", 32'(bus2.mem_read), 32'd0);
    chk("abort_ready", 32'(bus2.req_ready), 32'd1);
    chk("abort_rdata_reset", bus2.resp_rdata, 32'h0);
    reset2 = 1'b0;
    resp_n = 0; rc = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus2.resp_valid) resp_n++;
      if (bus2.mem_read) rc++;
      @(negedge clk);
    end
    chk("abort_no_resp", 32'(resp_n), 32'd0);
    chk("abort_no_strobe", 32'(rc), 32'd0);

    chk("no_rd_wr_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
